regfile_hilo: RTL and testbench

- Receiving end of the writeback-to-register-file bus. Holds the 32x32 general-purpose register file and the HI/LO pair.
- Commits writeback results and decodes the HI/LO write operation.
- Serves two combinational GPR read ports plus HI/LO read ports to the decode stage.
- Same-cycle writes are forwarded to reads (write-before-read), so decode never sees a stale value from the instruction retiring this cycle.

---
 rtl/regfile_hilo_pkg.sv | 19 +
 rtl/regfile_hilo_hilo_reg.sv | 50 +++++
 rtl/regfile_hilo.sv | 78 +++++++
 tb/tb_regfile_hilo.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/regfile_hilo_pkg.sv
// Shared writeback-to-register-file bus layout and HI/LO operation encoding.
package regfile_hilo_pkg;

  localparam int unsigned WB_TO_RF_WD = 43;
  localparam int unsigned RF_ADDR_W   = 5;

  // hilo_op bit indices
  localparam int unsigned HILO_MTHI   = 0;
  localparam int unsigned HILO_MTLO   = 1;
  localparam int unsigned HILO_MULDIV = 2;
  localparam int unsigned HILO_OP_W   = 5;

  // Bus field offsets: {hilo_op[4:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}
  localparam int unsigned WB_WDATA_LSB   = 0;
  localparam int unsigned WB_WADDR_LSB   = 32;
  localparam int unsigned WB_WE_BIT      = 37;
  localparam int unsigned WB_HILO_OP_LSB = 38;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO register pair: op decode with mult/div priority and same-cycle read bypass.
module hilo_reg
  import regfile_hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [2:0]            hilo_op,
  input  logic [DATA_W-1:0]     rf_wdata,
  input  logic [2*DATA_W-1:0]   hilo_wdata,
  output logic [DATA_W-1:0]     hi_rdata,
  output logic [DATA_W-1:0]     lo_rdata
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_next;
  logic [DATA_W-1:0] lo_next;

  // Mult/div commit takes precedence over mthi/mtlo on the register it targets.
  always_comb begin
    hi_we   = hilo_op[HILO_MULDIV] | hilo_op[HILO_MTHI];
    lo_we   = hilo_op[HILO_MULDIV] | hilo_op[HILO_MTLO];
    hi_next = rf_wdata;
    lo_next = rf_wdata;
    if (hilo_op[HILO_MULDIV]) begin
      hi_next = hilo_wdata[2*DATA_W-1:DATA_W];
      lo_next = hilo_wdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_next;
      if (lo_we) lo_q <= lo_next;
    end
  end

  always_comb begin
    hi_rdata = hi_we ? hi_next : hi_q;
    lo_rdata = lo_we ? lo_next : lo_q;
  end

endmodule

// File: rtl/regfile_hilo.sv
// Register file endpoint of the writeback bus: 32x32 GPRs with r0 hardwired to
// zero, two bypassed combinational read ports, and the HI/LO pair.
module regfile_hilo #(
  parameter int unsigned WB_TO_RF_WD = 43,
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [63:0]            hilo_wdata,
  input  logic [4:0]             raddr1,
  output logic [31:0]            rdata1,
  input  logic [4:0]             raddr2,
  output logic [31:0]            rdata2,
  output logic [31:0]            hi_rdata,
  output logic [31:0]            lo_rdata
);

  import regfile_hilo_pkg::*;

  logic [HILO_OP_W-1:0] hilo_op;
  logic                 rf_we;
  logic [RF_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic                 unused_rsvd;

  always_comb begin
    hilo_op  = wb_to_rf_bus[WB_HILO_OP_LSB +: HILO_OP_W];
    rf_we    = wb_to_rf_bus[WB_WE_BIT];
    rf_waddr = wb_to_rf_bus[WB_WADDR_LSB +: RF_ADDR_W];
    rf_wdata = wb_to_rf_bus[WB_WDATA_LSB +: DATA_W];
  end

  // hilo_op[4:3] are reserved and deliberately ignored.
  assign unused_rsvd = |hilo_op[4:3];

  logic [DATA_W-1:0] regs [REG_NUM];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we && (rf_waddr != '0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  always_comb begin
    if (raddr1 == '0)
      rdata1 = '0;
    else if (rf_we && (rf_waddr == raddr1))
      rdata1 = rf_wdata;
    else
      rdata1 = regs[raddr1];

    if (raddr2 == '0)
      rdata2 = '0;
    else if (rf_we && (rf_waddr == raddr2))
      rdata2 = rf_wdata;
    else
      rdata2 = regs[raddr2];
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo_reg (
    .clk        (clk),
    .resetn     (resetn),
    .hilo_op    (hilo_op[2:0]),
    .rf_wdata   (rf_wdata),
    .hilo_wdata (hilo_wdata),
    .hi_rdata   (hi_rdata),
    .lo_rdata   (lo_rdata)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: stimulus pushes hand-computed expectations,
// a monitor pops and compares on the falling edge.
module tb_regfile_hilo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [42:0] wb_to_rf_bus;
  logic [63:0] hilo_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  bit          stim_done = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_hilo #(
    .WB_TO_RF_WD (43),
    .REG_NUM     (32),
    .DATA_W      (32)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wb_to_rf_bus (wb_to_rf_bus),
    .hilo_wdata   (hilo_wdata),
    .raddr1       (raddr1),
    .rdata1       (rdata1),
    .raddr2       (raddr2),
    .rdata2       (rdata2),
    .hi_rdata     (hi_rdata),
    .lo_rdata     (lo_rdata)
  );

  function automatic logic [42:0] wb(input logic [4:0] op, input logic we,
                                     input logic [4:0] a, input logic [31:0] d);
    return {op, we, a, d};
  endfunction

  task automatic apply(input string name, input logic rst_n, input logic [42:0] bus,
                       input logic [63:0] hw, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    @(posedge clk);
    #2;
    resetn       = rst_n;
    wb_to_rf_bus = bus;
    hilo_wdata   = hw;
    raddr1       = a1;
    raddr2       = a2;
    e.name = name;
    e.r1 = e1;
    e.r2 = e2;
    e.hi = eh;
    e.lo = el;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "rdata1", rdata1, e.r1);
        cmp(e.name, "rdata2", rdata2, e.r2);
        cmp(e.name, "hi",     hi_rdata, e.hi);
        cmp(e.name, "lo",     lo_rdata, e.lo);
      end
    end
  end

  localparam logic [42:0] BUB = '0;
  localparam logic [63:0] HJ  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin : stimulus
    resetn       = 1'b0;
    wb_to_rf_bus = '0;
    hilo_wdata   = '0;
    raddr1       = '0;
    raddr2       = '0;

    //     name                rst  bus                                  hilo_wdata              a1 a2  rdata1        rdata2        hi            lo
    apply("reset_init",       0, BUB,                                 64'h0,                  0, 0,  32'h0,        32'h0,        32'h0,        32'h0);
    apply("wr3_bypass",       1, wb(5'd0, 1, 5'd3, 32'hDEADBEEF),    64'h0,                  3, 0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0);
    apply("wr3_held",         1, BUB,                                 HJ,                     3, 0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0);
    apply("r0_write",         1, wb(5'd0, 1, 5'd0, 32'h12345678),    64'h0,                  3, 0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0);
    apply("r0_next",          1, BUB,                                 64'h0,                  0, 0,  32'h0,        32'h0,        32'h0,        32'h0);
    apply("wr7",              1, wb(5'd0, 1, 5'd7, 32'h11),          64'h0,                  7, 0,  32'h11,       32'h0,        32'h0,        32'h0);
    apply("wr9",              1, wb(5'd0, 1, 5'd9, 32'h22),          64'h0,                  7, 9,  32'h11,       32'h22,       32'h0,        32'h0);
    apply("dual_bypass",      1, wb(5'd0, 1, 5'd9, 32'h33),          64'h0,                  7, 9,  32'h11,       32'h33,       32'h0,        32'h0);
    apply("dual_held",        1, BUB,                                 64'h0,                  9, 3,  32'h33,       32'hDEADBEEF, 32'h0,        32'h0);
    apply("muldiv",           1, wb(5'd4, 0, 5'd0, 32'h0),           64'hAAAA0000_5555FFFF,  7, 9,  32'h11,       32'h33,       32'hAAAA0000, 32'h5555FFFF);
    apply("muldiv_held",      1, BUB,                                 HJ,                     7, 9,  32'h11,       32'h33,       32'hAAAA0000, 32'h5555FFFF);
    apply("mthi",             1, wb(5'd1, 0, 5'd0, 32'h1),           HJ,                     7, 9,  32'h11,       32'h33,       32'h1,        32'h5555FFFF);
    apply("mthi_held",        1, BUB,                                 64'h0,                  7, 9,  32'h11,       32'h33,       32'h1,        32'h5555FFFF);
    apply("prio_muldiv_mthi", 1, wb(5'd5, 0, 5'd0, 32'h7),           64'h00000009_00000008,  7, 9,  32'h11,       32'h33,       32'h9,        32'h8);
    apply("prio_held",        1, BUB,                                 HJ,                     7, 9,  32'h11,       32'h33,       32'h9,        32'h8);
    apply("mthi_mtlo",        1, wb(5'd3, 0, 5'd0, 32'hC),           HJ,                     7, 9,  32'h11,       32'h33,       32'hC,        32'hC);
    apply("gpr_and_mtlo",     1, wb(5'd2, 1, 5'd5, 32'h5A),          HJ,                     5, 7,  32'h5A,       32'h11,       32'hC,        32'h5A);
    apply("rsvd_bits",        1, wb(5'h18, 0, 5'd5, 32'h99),         HJ,                     5, 7,  32'h5A,       32'h11,       32'hC,        32'h5A);
    apply("prio_muldiv_mtlo", 1, wb(5'd6, 0, 5'd0, 32'h77),          64'h00000003_00000004,  5, 3,  32'h5A,       32'hDEADBEEF, 32'h3,        32'h4);
    apply("hilo_final_held",  1, BUB,                                 HJ,                     5, 3,  32'h5A,       32'hDEADBEEF, 32'h3,        32'h4);
    apply("reset_async",      0, BUB,                                 64'h0,                  5, 9,  32'h0,        32'h0,        32'h0,        32'h0);
    apply("reset_midwrite",   0, wb(5'd0, 1, 5'd5, 32'hFFFF),        64'h0,                  0, 0,  32'h0,        32'h0,        32'h0,        32'h0);
    apply("post_reset",       1, BUB,                                 HJ,                     5, 3,  32'h0,        32'h0,        32'h0,        32'h0);

    stim_done = 1'b1;
  end

  initial begin : finisher
    int unsigned budget;
    wait (stim_done);
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
